// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage with a one-entry retired-write history for decode forwarding.
// Optional retired-instruction counter is enabled by defining RETIRE_COUNT_EN.
module mem_wb_stage #(
  parameter int DATA_W             = 16,
  parameter int REG_ADDR_W         = 3,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  memtoReg5,
  input  logic                  regWrite5,
  input  logic [DATA_W-1:0]     rdData3,
  input  logic [DATA_W-1:0]     aluResultOut2,
  input  logic [REG_ADDR_W-1:0] wrReg_in,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  output logic                  regWrEn,
  output logic [REG_ADDR_W-1:0] regWrAddr,
  output logic [DATA_W-1:0]     regWrData,
  output logic                  fwdA_hit,
  output logic [DATA_W-1:0]     fwdA_data,
  output logic                  fwdB_hit,
  output logic [DATA_W-1:0]     fwdB_data
`ifdef RETIRE_COUNT_EN
  ,
  output logic [15:0]           retire_count
`endif
);

  localparam bit ZeroHard = (ZERO_REG_HARDWIRED != 0);

  logic                  valid_q;
  logic                  memtoReg_q;
  logic                  regWrite_q;
  logic [REG_ADDR_W-1:0] wrReg_q;
  logic [DATA_W-1:0]     aluRes_q;
  logic [DATA_W-1:0]     memData_q;

  logic                  hist_valid;
  logic [REG_ADDR_W-1:0] hist_addr;
  logic [DATA_W-1:0]     hist_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      memtoReg_q <= 1'b0;
      regWrite_q <= 1'b0;
      wrReg_q    <= '0;
      aluRes_q   <= '0;
      memData_q  <= '0;
      hist_valid <= 1'b0;
      hist_addr  <= '0;
      hist_data  <= '0;
    end else begin
      if (flush) begin
        valid_q    <= 1'b0;
        memtoReg_q <= 1'b0;
        regWrite_q <= 1'b0;
        wrReg_q    <= '0;
        aluRes_q   <= '0;
        memData_q  <= '0;
      end else if (!stall) begin
        valid_q    <= valid_in;
        memtoReg_q <= memtoReg5;
        regWrite_q <= regWrite5;
        wrReg_q    <= wrReg_in;
        aluRes_q   <= aluResultOut2;
        memData_q  <= rdData3;
      end
      // A stalled write is repeated next cycle, so only record it once it actually leaves.
      if (regWrEn && !stall) begin
        hist_valid <= 1'b1;
        hist_addr  <= regWrAddr;
        hist_data  <= regWrData;
      end
    end
  end

  assign regWrEn   = valid_q && regWrite_q && !(ZeroHard && (wrReg_q == '0));
  assign regWrAddr = wrReg_q;
  assign regWrData = memtoReg_q ? memData_q : aluRes_q;

  logic [REG_ADDR_W-1:0] rsSel   [2];
  logic [1:0]            fwdHit;
  logic [DATA_W-1:0]     fwdData [2];

  assign rsSel[0] = rs1_id;
  assign rsSel[1] = rs2_id;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi = gi + 1) begin : g_fwd
      logic curHit;
      logic histHit;
      // The in-flight write is newer than history, so it wins when both match.
      assign curHit       = regWrEn && (rsSel[gi] == wrReg_q);
      assign histHit      = hist_valid && (rsSel[gi] == hist_addr) &&
                            !(ZeroHard && (rsSel[gi] == '0));
      assign fwdHit[gi]   = curHit || histHit;
      assign fwdData[gi]  = curHit ? regWrData : (histHit ? hist_data : '0);
    end
  endgenerate

  assign fwdA_hit  = fwdHit[0];
  assign fwdA_data = fwdData[0];
  assign fwdB_hit  = fwdHit[1];
  assign fwdB_data = fwdData[1];

`ifdef RETIRE_COUNT_EN
  logic [15:0] retireCnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retireCnt_q <= '0;
    end else if (valid_q && !stall && (retireCnt_q != 16'hFFFF)) begin
      retireCnt_q <= retireCnt_q + 16'd1;
    end
  end

  assign retire_count = retireCnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed plan steps plus randomized cycles against a write-level reference model.
// Define RETIRE_COUNT_EN to also exercise the retire counter and its saturation.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        stall;
  logic        flush;
  logic        memtoReg5;
  logic        regWrite5;
  logic [15:0] rdData3;
  logic [15:0] aluResultOut2;
  logic [2:0]  wrReg_in;
  logic [2:0]  rs1_id;
  logic [2:0]  rs2_id;
  logic        regWrEn;
  logic [2:0]  regWrAddr;
  logic [15:0] regWrData;
  logic        fwdA_hit;
  logic [15:0] fwdA_data;
  logic        fwdB_hit;
  logic [15:0] fwdB_data;
`ifdef RETIRE_COUNT_EN
  logic [15:0] retire_count;
`endif

  mem_wb_stage #(.DATA_W(16), .REG_ADDR_W(3), .ZERO_REG_HARDWIRED(1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
    .memtoReg5(memtoReg5), .regWrite5(regWrite5), .rdData3(rdData3),
    .aluResultOut2(aluResultOut2), .wrReg_in(wrReg_in), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .regWrEn(regWrEn), .regWrAddr(regWrAddr), .regWrData(regWrData),
    .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data), .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data)
`ifdef RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the write the WB entry will perform, and the list of writes that have retired.
  typedef struct {
    bit          valid;
    bit          en;
    logic [2:0]  addr;
    logic [15:0] data;
  } wb_t;

  wb_t pend;
  wb_t retired[$];
  int  expCount;
  int  compared;
  int  mismatched;
  int  cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void lookup(input logic [2:0] rs, output logic h, output logic [15:0] d);
    h = 1'b0;
    d = 16'h0;
    if (pend.en && rs == pend.addr) begin
      h = 1'b1;
      d = pend.data;
    end else if (retired.size() > 0 && rs != 3'd0 && rs == retired[$].addr) begin
      h = 1'b1;
      d = retired[$].data;
    end
  endfunction

  task automatic checkAll();
    logic        h;
    logic [15:0] d;
    chk("regWrEn", 32'(regWrEn), 32'(pend.en));
    chk("regWrAddr", 32'(regWrAddr), 32'(pend.addr));
    chk("regWrData", 32'(regWrData), 32'(pend.data));
    lookup(rs1_id, h, d);
    chk("fwdA_hit", 32'(fwdA_hit), 32'(h));
    chk("fwdA_data", 32'(fwdA_data), 32'(d));
    lookup(rs2_id, h, d);
    chk("fwdB_hit", 32'(fwdB_hit), 32'(h));
    chk("fwdB_data", 32'(fwdB_data), 32'(d));
`ifdef RETIRE_COUNT_EN
    chk("retire_count", 32'(retire_count), 32'(expCount));
`endif
    $display("cyc %0d: rst_n=%b v=%b st=%b fl=%b | wb en=%b r%0d=%h | fwdA %b/%h fwdB %b/%h",
             cyc, rst_n, valid_in, stall, flush, regWrEn, regWrAddr, regWrData,
             fwdA_hit, fwdA_data, fwdB_hit, fwdB_data);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      pend = '{0, 0, 3'd0, 16'h0};
      retired.delete();
      expCount = 0;
    end else begin
      if (pend.en && !stall) begin
        retired.push_back(pend);
        if (retired.size() > 4) void'(retired.pop_front());
      end
      if (pend.valid && !stall && expCount < 65535) expCount++;
      if (flush) pend = '{0, 0, 3'd0, 16'h0};
      else if (!stall) begin
        pend.valid = valid_in;
        pend.en    = valid_in && regWrite5 && (wrReg_in != 3'd0);
        pend.addr  = wrReg_in;
        pend.data  = memtoReg5 ? rdData3 : aluResultOut2;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    settle();
    checkAll();
    advance();
  endtask

  task automatic drive(input logic v, input logic mtr, input logic rw,
                       input logic [15:0] alu, input logic [15:0] mem, input logic [2:0] rd);
    valid_in = v; memtoReg5 = mtr; regWrite5 = rw;
    aluResultOut2 = alu; rdData3 = mem; wrReg_in = rd;
  endtask

  initial begin
    compared = 0; mismatched = 0; cyc = 0; expCount = 0;
    pend = '{0, 0, 3'd0, 16'h0};
    rst_n = 1'b0; stall = 1'b1; flush = 1'b0; rs1_id = 3'd0; rs2_id = 3'd0;
    drive(1'b1, 1'b0, 1'b1, 16'h7777, 16'h8888, 3'd1);

    // Reset held two cycles while a valid, stalled instruction is presented.
    advance();
    advance();
    rst_n = 1'b1; stall = 1'b0; valid_in = 1'b0; rs1_id = 3'd1;
    settle();
    checkAll();
    chk("rst_regWrEn", 32'(regWrEn), 32'd0);
    chk("rst_fwdA_hit", 32'(fwdA_hit), 32'd0);
`ifdef RETIRE_COUNT_EN
    chk("rst_retire_count", 32'(retire_count), 32'd0);
`endif
    advance();

    // ALU writeback to r3, forwarded to source A.
    drive(1'b1, 1'b0, 1'b1, 16'h1234, 16'h4321, 3'd3);
    rs1_id = 3'd3;
    step();
    valid_in = 1'b0;
    settle();
    checkAll();
    chk("alu_regWrEn", 32'(regWrEn), 32'd1);
    chk("alu_regWrAddr", 32'(regWrAddr), 32'd3);
    chk("alu_regWrData", 32'(regWrData), 32'h1234);
    chk("alu_fwdA_hit", 32'(fwdA_hit), 32'd1);
    chk("alu_fwdA_data", 32'(fwdA_data), 32'h1234);
    advance();

    // Load to r5, then a bubble: source B must be served from history.
    drive(1'b1, 1'b1, 1'b1, 16'h0F0F, 16'hBEEF, 3'd5);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    rs2_id = 3'd5;
    step();
    settle();
    checkAll();
    chk("hist_regWrEn", 32'(regWrEn), 32'd0);
    chk("hist_fwdB_hit", 32'(fwdB_hit), 32'd1);
    chk("hist_fwdB_data", 32'(fwdB_data), 32'hBEEF);
    advance();

    // Capture r2 = 00AA, stall three cycles, then flush while still stalled.
    drive(1'b1, 1'b0, 1'b1, 16'h00AA, 16'h1111, 3'd2);
    step();
    drive(1'b1, 1'b0, 1'b1, 16'h5555, 16'h6666, 3'd6);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkAll();
      chk("stall_regWrEn", 32'(regWrEn), 32'd1);
      chk("stall_regWrData", 32'(regWrData), 32'h00AA);
      advance();
    end
    flush = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
    settle();
    checkAll();
    chk("flush_regWrEn", 32'(regWrEn), 32'd0);
    advance();

    // Write to r0 is suppressed and must not disturb history (r5 = BEEF).
    drive(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h2222, 3'd0);
    rs1_id = 3'd0;
    step();
    valid_in = 1'b0;
    settle();
    checkAll();
    chk("zero_regWrEn", 32'(regWrEn), 32'd0);
    chk("zero_fwdA_hit", 32'(fwdA_hit), 32'd0);
    advance();
    rs2_id = 3'd5;
    settle();
    checkAll();
    chk("zero_hist_data", 32'(fwdB_data), 32'hBEEF);
    advance();

    // Current write beats history for the same register.
    drive(1'b1, 1'b0, 1'b1, 16'h0001, 16'h0, 3'd4);
    step();
    drive(1'b1, 1'b0, 1'b1, 16'h0002, 16'h0, 3'd4);
    step();
    valid_in = 1'b0;
    rs1_id = 3'd4;
    settle();
    checkAll();
    chk("prio_fwdA_data", 32'(fwdA_data), 32'h0002);
    advance();

    // Randomized traffic with occasional resets, stalls and flushes.
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
            16'($urandom), 16'($urandom), 3'($urandom));
      rs1_id = 3'($urandom);
      rs2_id = 3'($urandom);
      step();
    end

`ifdef RETIRE_COUNT_EN
    // Drive the counter to its ceiling, then confirm it sticks there.
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 3'd1);
    for (int i = 0; i < 70000 && expCount < 65535; i++) advance();
    settle();
    checkAll();
    chk("sat_reach", 32'(retire_count), 32'hFFFF);
    advance();
    advance();
    settle();
    checkAll();
    chk("sat_hold", 32'(retire_count), 32'hFFFF);
    advance();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
